// File: rtl/clock_divider_bank_if.sv
// Config port of the clock divider bank.
// Master issues requests; slave reports ready, error and busy.
interface clock_divider_bank_if #(
  parameter int CHAN_W = 2,
  parameter int CNT_W  = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [CNT_W-1:0]  cfg_half;
  logic              cfg_err;
  logic              busy;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_half,
    input  cfg_ready,
    input  cfg_err,
    input  busy
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_half,
    output cfg_ready,
    output cfg_err,
    output busy
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of glitch-free clock dividers with run-time ratio updates.
// Ratio changes land only on a channel's 1->0 period boundary.
module clock_divider_bank #(
  parameter int                N_CHAN       = 4,
  parameter int                CNT_W        = 8,
  parameter int                CHAN_W       = 2,
  parameter logic [CNT_W-1:0]  DEFAULT_HALF = CNT_W'(1),
  parameter logic [N_CHAN-1:0] INVERT_MASK  = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  clock_divider_bank_if.slave cfg,
  output logic [N_CHAN-1:0] div_clk,
  output logic [N_CHAN-1:0] rise_tick,
  output logic [N_CHAN-1:0] fall_tick
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DONE
  } state_t;

  state_t                        state;
  logic [CHAN_W-1:0]             pend_chan;
  logic [CNT_W-1:0]              pend_half;
  logic [N_CHAN-1:0]             phase;
  logic [N_CHAN-1:0][CNT_W-1:0]  cnt;
  logic [N_CHAN-1:0][CNT_W-1:0]  half_act;
  logic [N_CHAN-1:0]             apply;
  logic                          chan_bad;

  assign chan_bad = int'(cfg.cfg_chan) >= N_CHAN;

  // Pending update lands at the target's 1->0 edge, or at once when stopped.
  always_comb begin
    apply = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (state == PEND && pend_chan == CHAN_W'(i)) begin
        apply[i] = !enable || (cnt[i] == '0 && phase[i]);
      end
    end
  end

  // Config slot: accept, hold until applied, free one edge later.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      pend_chan     <= '0;
      pend_half     <= '0;
      cfg.cfg_ready <= 1'b1;
      cfg.busy      <= 1'b0;
      cfg.cfg_err   <= 1'b0;
    end else begin
      cfg.cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cfg.cfg_valid) begin
            if (chan_bad) begin
              cfg.cfg_err <= 1'b1;
            end else begin
              state         <= PEND;
              pend_chan     <= cfg.cfg_chan;
              pend_half     <= cfg.cfg_half;
              cfg.cfg_ready <= 1'b0;
              cfg.busy      <= 1'b1;
            end
          end
        end
        PEND: begin
          if (|apply) begin
            state <= DONE;
          end
        end
        DONE: begin
          state         <= IDLE;
          cfg.cfg_ready <= 1'b1;
          cfg.busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Per-channel down counters, phase toggle, registered clocks and ticks.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N_CHAN; i++) begin
        cnt[i]      <= DEFAULT_HALF;
        half_act[i] <= DEFAULT_HALF;
      end
      phase     <= '0;
      div_clk   <= INVERT_MASK;
      rise_tick <= '0;
      fall_tick <= '0;
    end else begin
      rise_tick <= '0;
      fall_tick <= '0;
      for (int i = 0; i < N_CHAN; i++) begin
        if (enable) begin
          if (cnt[i] == '0) begin
            phase[i]     <= ~phase[i];
            div_clk[i]   <= ~phase[i] ^ INVERT_MASK[i];
            rise_tick[i] <= ~phase[i] ^ INVERT_MASK[i];
            fall_tick[i] <= phase[i] ^ INVERT_MASK[i];
            cnt[i]       <= half_act[i];
          end else begin
            cnt[i] <= cnt[i] - 1'b1;
          end
        end
        if (apply[i]) begin
          cnt[i]      <= pend_half;
          half_act[i] <= pend_half;
        end
      end
    end
  end

endmodule
